// File: rtl/div_arb_pkg.sv
// Shared widths, constants and tag type for the divider arbiter and its pipelined divider core.
package div_arb_pkg;

  localparam int unsigned DIV_DIVIDEND_W  = 20;
  localparam int unsigned DIV_DIVISOR_W   = 10;
  localparam int unsigned DIV_QUOT_W      = 20;
  localparam int unsigned DIV_LAT_DEFAULT = 24;

  // Wide enough for the largest supported requester count (8).
  localparam int unsigned TAG_ID_W = 3;

  localparam logic [DIV_QUOT_W-1:0] DZ_QUOT = 20'hFFFFF;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                dz;
  } div_tag_t;

endpackage

// File: rtl/div_arb_tag_pipe.sv
// Fixed-length shift register of in-flight op tags, cleared by synchronous active-low reset.
module div_arb_tag_pipe
  import div_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DIV_LAT_DEFAULT + 1
) (
  input  logic     clk,
  input  logic     reset_n,
  input  div_tag_t tag_in,
  output div_tag_t tag_out,
  output logic     any_valid
);

  div_tag_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | stage_q[i].valid;
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/divider.sv
// Pipelined unsigned divider core: one op per cycle, quotient appears LAT cycles after the operands.
module divider
  import div_arb_pkg::*;
#(
  parameter int unsigned LAT = DIV_LAT_DEFAULT
) (
  input  logic                      clk,
  input  logic [DIV_DIVIDEND_W-1:0] dividend,
  input  logic [DIV_DIVISOR_W-1:0]  divisor,
  output logic [DIV_QUOT_W-1:0]     quotient
);

  logic [DIV_QUOT_W-1:0] q_comb;
  logic [DIV_QUOT_W-1:0] pipe_q [LAT];

  always_comb begin
    q_comb = dividend / DIV_DIVIDEND_W'(divisor);
  end

  // No reset: consumers qualify the output with their own valid tracking.
  always_ff @(posedge clk) begin
    pipe_q[0] <= q_comb;
    for (int unsigned i = 1; i < LAT; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign quotient = pipe_q[LAT-1];

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sharing of one pipelined divider among NREQ requesters, results tagged by id.
// Optional macro DIV_ARBITER_PRIO0_EN gives requester 0 absolute priority.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT,
  parameter int unsigned IDW     = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NREQ-1:0]                req,
  input  logic [DIV_DIVIDEND_W*NREQ-1:0] dividend_bus,
  input  logic [DIV_DIVISOR_W*NREQ-1:0]  divisor_bus,
  output logic [NREQ-1:0]                gnt,
  output logic                           result_valid,
  output logic [IDW-1:0]                 result_id,
  output logic [DIV_QUOT_W-1:0]          result_q,
  output logic                           result_dz,
  output logic                           busy
);

  logic [IDW-1:0]            rr_ptr;
  logic [IDW-1:0]            gnt_id;
  logic                      gnt_any;
  logic                      rr_upd;
  logic [DIV_DIVIDEND_W-1:0] sel_dividend;
  logic [DIV_DIVISOR_W-1:0]  sel_divisor;
  logic                      issue_valid;
  logic [DIV_DIVIDEND_W-1:0] issue_dividend;
  logic [DIV_DIVISOR_W-1:0]  issue_divisor;
  logic [DIV_QUOT_W-1:0]     div_q;
  div_tag_t                  tag_in;
  div_tag_t                  tag_out;
  logic                      tag_any;

  always_comb begin
    int unsigned sum;
    logic [IDW-1:0] idx;
    gnt_any = 1'b0;
    gnt_id  = '0;
    sum     = 0;
    idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = 32'(rr_ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IDW'(sum);
`ifdef DIV_ARBITER_PRIO0_EN
      if (!gnt_any && idx != '0 && req[idx]) begin
`else
      if (!gnt_any && req[idx]) begin
`endif
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
`ifdef DIV_ARBITER_PRIO0_EN
    rr_upd = gnt_any;
    if (req[0]) begin
      gnt_any = 1'b1;
      gnt_id  = '0;
      rr_upd  = 1'b0;
    end
`else
    rr_upd = gnt_any;
`endif
    if (!reset_n) begin
      gnt_any = 1'b0;
      rr_upd  = 1'b0;
    end
  end

  assign gnt = gnt_any ? (NREQ'(1) << gnt_id) : '0;

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (32'(gnt_id) == i) begin
        sel_dividend = dividend_bus[i*DIV_DIVIDEND_W +: DIV_DIVIDEND_W];
        sel_divisor  = divisor_bus[i*DIV_DIVISOR_W +: DIV_DIVISOR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (rr_upd) begin
      rr_ptr <= (32'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IDW'(1);
    end
  end

  // A zero divisor still issues with divisor 1; the result is overridden at the output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      issue_valid    <= 1'b0;
      issue_dividend <= '0;
      issue_divisor  <= '0;
    end else begin
      issue_valid <= gnt_any;
      if (gnt_any) begin
        issue_dividend <= sel_dividend;
        issue_divisor  <= (sel_divisor == '0) ? DIV_DIVISOR_W'(1) : sel_divisor;
      end
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = gnt_any;
    tag_in.id    = TAG_ID_W'(gnt_id);
    tag_in.dz    = gnt_any && (sel_divisor == '0);
  end

  divider #(
    .LAT(DIV_LAT)
  ) u_divider (
    .clk      (clk),
    .dividend (issue_dividend),
    .divisor  (issue_divisor),
    .quotient (div_q)
  );

  div_arb_tag_pipe #(
    .DEPTH(DIV_LAT + 1)
  ) u_tag_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .tag_in    (tag_in),
    .tag_out   (tag_out),
    .any_valid (tag_any)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result_valid <= 1'b0;
      result_id    <= '0;
      result_q     <= '0;
      result_dz    <= 1'b0;
    end else begin
      result_valid <= tag_out.valid;
      if (tag_out.valid) begin
        result_id <= tag_out.id[IDW-1:0];
        result_dz <= tag_out.dz;
        result_q  <= tag_out.dz ? DZ_QUOT : div_q;
      end
    end
  end

  assign busy = issue_valid | tag_any;

endmodule
